capture_timer: RTL and testbench
================================

Name: capture_timer

Overview:
- Input-capture counterpart of the interval timer: it measures the time between selected edges of an external signal instead of generating a timed interrupt.
- Uses the same prescaler encoding as the interval timer.
- Latches a 16-bit tick count and raises an interrupt.
- Sits beside the interval timer on the PicoBlaze peripheral bus; the bus glue drives the configuration and acknowledge inputs.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on cap_in (minimum 2).

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- prescaler_conf  input  3  tick period = 2^prescaler_conf clk_in cycles
- en  input  1  block enable (H)
- arm  input  1  single-cycle pulse; starts or restarts a measurement
- auto_load  input  1  continuous mode (H): re-measure after every capture
- edge_sel  input  2  00 rise-rise, 01 fall-fall, 10 any-any, 11 rise-fall (high pulse width)
- cap_in  input  1  asynchronous external signal
- int_ack  input  1  single-cycle pulse; clears cap_int
- capture  output  16  last captured tick count
- cap_int  output  1  capture interrupt (H), level
- overflow  output  1  sticky; count saturated during measurement
- overrun  output  1  sticky; capture occurred while cap_int still set
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; capture=0000; cap_int, overflow, overrun, busy=0; tick counter, prescaler and synchronizer cleared to 0.
- Sync/edge detect:
  - cap_in passes through SYNC_STAGES flops, then one delay flop.
  - rise = sync & ~dly; fall = ~sync & dly.
  - With SYNC_STAGES=2, a cap_in change meeting setup before clock k is acted on at clock k+2.
- Config latch: edge_sel and auto_load are registered on an accepted arm. Changes mid-measurement are ignored. prescaler_conf is used live.
- States:
  - IDLE: arm & en -> WAIT_FIRST.
  - WAIT_FIRST: start edge (rise for 00/11, fall for 01, either for 10) -> MEASURE; counter<=0, prescaler<=0.
  - MEASURE, stop edge (rise 00, fall 01, either 10, fall 11):
    - capture <= counter + tick, saturated at FFFF.
    - cap_int <= 1.
    - If cap_int was already 1 and int_ack is not asserted this cycle, overrun <= 1.
    - Next state if auto_load=0: IDLE.
    - Next state if auto_load=1 and edge_sel != 11: stay in MEASURE; counter<=0, prescaler<=0. The stop edge is also the next start edge.
    - Next state if auto_load=1 and edge_sel == 11: WAIT_FIRST.
- Prescaler:
  - 7-bit count, runs only in MEASURE.
  - tick = (prescaler == 2^conf - 1); the prescaler wraps to 0 on tick.
  - Result: a stop edge N clocks after the start edge yields capture = floor(N / 2^conf), or FFFF if saturated.
- Counter:
  - 16-bit, increments on tick in MEASURE.
  - At FFFF it holds and sets overflow=1, even if no capture follows.
- cap_int:
  - Cleared by int_ack.
  - Capture and int_ack in the same cycle -> cap_int=1, overrun unchanged.
- arm while en=1 in any state:
  - Go to WAIT_FIRST.
  - Clear cap_int, overflow, overrun and counter.
  - capture retained.
- en=0:
  - State forced to IDLE; counter and prescaler cleared; arm ignored.
  - capture, cap_int, overflow and overrun retained; int_ack still honoured.
- Reset mid-measurement: identical to power-on reset. No capture is produced; a stop edge in the same cycle as rst is ignored.
- Start edge and stop edge are never taken in the same cycle. In mode 10, an edge in WAIT_FIRST only starts the measurement.

Test Plan:
- Reset, en=1, conf=0, edge_sel=00, arm. Rising edges on cap_in 40 clocks apart -> capture=0028, cap_int=1, busy=0 after stop. int_ack -> cap_int=0.
- conf=3, edge_sel=11. High pulse of 100 clocks -> capture=000C (floor 100/8), overflow=0.
- conf=0, auto_load=1, edge_sel=00, rising edges every 30 clocks:
  - each capture = 001E, busy stays 1;
  - no int_ack between captures -> overrun=1 on the second capture;
  - int_ack in the same cycle as a capture -> cap_int=1, overrun unchanged.
- conf=0, start edge, no stop edge for 70000 clocks -> overflow=1 once the count reaches FFFF. A later stop edge -> capture=FFFF. arm -> overflow=0, state WAIT_FIRST.
- Mid-MEASURE rst=1 for one cycle -> all outputs 0 and state IDLE. A stop edge afterwards -> no cap_int.
- Mid-MEASURE en=0 -> busy=0, capture and cap_int unchanged. en=1 with no arm -> edges ignored. arm with en=0 -> no effect.

Source files
------------

// File: rtl/capture_timer.sv
// Input-capture timer: measures prescaled tick counts between selected edges of
// an asynchronous input, latches the result and raises a level interrupt.
module capture_timer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [2:0]  prescaler_conf,
    input  logic        en,
    input  logic        arm,
    input  logic        auto_load,
    input  logic [1:0]  edge_sel,
    input  logic        cap_in,
    input  logic        int_ack,
    output logic [15:0] capture,
    output logic        cap_int,
    output logic        overflow,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PRESC_W = 7;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [CNT_W-1:0]       counter;
    logic [PRESC_W-1:0]     presc;
    logic [1:0]             edge_q;
    logic                   auto_q;

    logic                   sync_c;
    logic                   rise_c;
    logic                   fall_c;
    logic                   start_edge_c;
    logic                   stop_edge_c;
    logic                   tick_c;
    logic [7:0]             period_c;
    logic [CNT_W:0]         sum_c;
    logic [CNT_W-1:0]       cap_val_c;

    // Edge detection on the synchronized input
    assign sync_c = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_c & ~dly_q;
    assign fall_c = ~sync_c & dly_q;

    always_comb begin
        start_edge_c = 1'b0;
        stop_edge_c  = 1'b0;
        case (edge_q)
            2'b00: begin start_edge_c = rise_c;          stop_edge_c = rise_c;          end
            2'b01: begin start_edge_c = fall_c;          stop_edge_c = fall_c;          end
            2'b10: begin start_edge_c = rise_c | fall_c; stop_edge_c = rise_c | fall_c; end
            default: begin start_edge_c = rise_c;        stop_edge_c = fall_c;          end
        endcase
    end

    // Tick fires on the last prescaler count of each 2^conf period
    assign period_c  = 8'd1 << prescaler_conf;
    assign tick_c    = (presc == 7'(period_c - 8'd1));
    assign sum_c     = {1'b0, counter} + 17'(tick_c);
    assign cap_val_c = sum_c[CNT_W] ? 16'hFFFF : sum_c[CNT_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else if (arm) begin
            state_nxt = WAIT_FIRST;
        end else begin
            case (state)
                WAIT_FIRST: if (start_edge_c) state_nxt = MEASURE;
                MEASURE: begin
                    if (stop_edge_c) begin
                        if (!auto_q)                state_nxt = IDLE;
                        else if (edge_q == 2'b11)   state_nxt = WAIT_FIRST;
                        else                        state_nxt = MEASURE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q   <= '0;
            dly_q    <= 1'b0;
            counter  <= '0;
            presc    <= '0;
            edge_q   <= 2'b00;
            auto_q   <= 1'b0;
            capture  <= '0;
            cap_int  <= 1'b0;
            overflow <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
            dly_q  <= sync_c;
            busy   <= (state_nxt != IDLE);
            if (int_ack) cap_int <= 1'b0;

            if (!en) begin
                counter <= '0;
                presc   <= '0;
            end else if (arm) begin
                cap_int  <= 1'b0;
                overflow <= 1'b0;
                overrun  <= 1'b0;
                counter  <= '0;
                presc    <= '0;
                edge_q   <= edge_sel;
                auto_q   <= auto_load;
            end else begin
                case (state)
                    WAIT_FIRST: begin
                        if (start_edge_c) begin
                            counter <= '0;
                            presc   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (stop_edge_c) begin
                            capture <= cap_val_c;
                            cap_int <= 1'b1;
                            if (cap_int && !int_ack) overrun <= 1'b1;
                            // In continuous mode the stop edge doubles as the next start edge
                            if (auto_q && edge_q != 2'b11) begin
                                counter <= '0;
                                presc   <= '0;
                            end
                        end else begin
                            presc <= tick_c ? '0 : presc + 7'd1;
                            if (tick_c && counter != 16'hFFFF) counter <= counter + 16'd1;
                            if (tick_c && counter >= 16'hFFFE) overflow <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_timer.sv
// Scoreboard bench for capture_timer: expected captures are queued as edges are
// driven and compared against the capture register when the DUT latches them.
module tb_capture_timer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  prescaler_conf = 3'd0;
    logic        en = 1'b0;
    logic        arm = 1'b0;
    logic        auto_load = 1'b0;
    logic [1:0]  edge_sel = 2'b00;
    logic        cap_in = 1'b0;
    logic        int_ack = 1'b0;
    logic [15:0] capture;
    logic        cap_int;
    logic        overflow;
    logic        overrun;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] exp_q[$];

    capture_timer #(.SYNC_STAGES(2)) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .prescaler_conf (prescaler_conf),
        .en             (en),
        .arm            (arm),
        .auto_load      (auto_load),
        .edge_sel       (edge_sel),
        .cap_in         (cap_in),
        .int_ack        (int_ack),
        .capture        (capture),
        .cap_int        (cap_int),
        .overflow       (overflow),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check_pop(input string tag);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, 32'(capture), 32'(exp));
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] e_cap, input logic e_int,
                                 input logic e_ovf, input logic e_ovr, input logic e_busy);
        check_eq({tag, "_capture"},  32'(capture),  32'(e_cap));
        check_eq({tag, "_cap_int"},  32'(cap_int),  32'(e_int));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(e_ovf));
        check_eq({tag, "_overrun"},  32'(overrun),  32'(e_ovr));
        check_eq({tag, "_busy"},     32'(busy),     32'(e_busy));
    endtask

    // One 30-clock period starting with a rising edge; capture lands 3 clocks after the rise
    task automatic rise_period(input bit expect_cap, input bit ack_same, input logic e_ovr, input string tag);
        cap_in = 1'b1;
        if (expect_cap) exp_q.push_back(16'd30);
        cyc(2);
        if (ack_same) int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        if (expect_cap) begin
            check_pop({tag, "_capture"});
            check_eq({tag, "_cap_int"}, 32'(cap_int), 1);
            check_eq({tag, "_overrun"}, 32'(overrun), 32'(e_ovr));
            check_eq({tag, "_busy"},    32'(busy),    1);
        end
        cyc(7);
        cap_in = 1'b0;
        cyc(20);
    endtask

    initial begin
        // Reset
        cyc(2);
        check_outputs("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1);

        // Rise-to-rise, conf 0, 40 clocks
        en = 1'b1;
        arm_pulse();
        check_eq("arm_busy", 32'(busy), 1);
        cap_in = 1'b1;
        cyc(10);
        cap_in = 1'b0;
        cyc(30);
        cap_in = 1'b1;
        exp_q.push_back(16'h0028);
        cyc(3);
        check_pop("rr40");
        check_eq("rr40_cap_int", 32'(cap_int), 1);
        check_eq("rr40_busy", 32'(busy), 0);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        check_eq("rr40_ack", 32'(cap_int), 0);
        cap_in = 1'b0;
        cyc(5);

        // High pulse width, conf 3, 100 clocks
        prescaler_conf = 3'd3;
        edge_sel = 2'b11;
        arm_pulse();
        cyc(1);
        cap_in = 1'b1;
        cyc(100);
        cap_in = 1'b0;
        exp_q.push_back(16'h000C);
        cyc(3);
        check_pop("pw100");
        check_eq("pw100_cap_int", 32'(cap_int), 1);
        check_eq("pw100_overflow", 32'(overflow), 0);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;

        // Continuous rise-to-rise, 30 clocks
        prescaler_conf = 3'd0;
        edge_sel = 2'b00;
        auto_load = 1'b1;
        arm_pulse();
        cyc(1);
        rise_period(1'b0, 1'b0, 1'b0, "auto0");
        rise_period(1'b1, 1'b0, 1'b0, "auto1");
        rise_period(1'b1, 1'b1, 1'b0, "auto2_ack");
        rise_period(1'b1, 1'b0, 1'b1, "auto3_ovr");

        // Counter saturation
        auto_load = 1'b0;
        arm_pulse();
        check_eq("sat_arm_overrun", 32'(overrun), 0);
        check_eq("sat_arm_cap_int", 32'(cap_int), 0);
        cap_in = 1'b1;
        cyc(10);
        cap_in = 1'b0;
        cyc(65520);
        check_eq("sat_pre_overflow", 32'(overflow), 0);
        cyc(10);
        check_eq("sat_overflow", 32'(overflow), 1);
        check_eq("sat_cap_int", 32'(cap_int), 0);
        cap_in = 1'b1;
        exp_q.push_back(16'hFFFF);
        cyc(3);
        check_pop("sat");
        check_eq("sat_stop_cap_int", 32'(cap_int), 1);
        arm_pulse();
        check_outputs("sat_rearm", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a measurement
        cap_in = 1'b0;
        cyc(5);
        cap_in = 1'b1;
        cyc(10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_outputs("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cap_in = 1'b0;
        cyc(5);
        cap_in = 1'b1;
        cyc(5);
        check_outputs("midrst_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Disable in the middle of a continuous measurement
        cap_in = 1'b0;
        auto_load = 1'b1;
        arm_pulse();
        cyc(3);
        cap_in = 1'b1;
        cyc(20);
        cap_in = 1'b0;
        cyc(5);
        cap_in = 1'b1;
        exp_q.push_back(16'h0019);
        cyc(3);
        check_pop("dis25");
        check_eq("dis25_busy", 32'(busy), 1);
        cyc(2);
        en = 1'b0;
        cyc(1);
        check_outputs("dis", 16'h0019, 1'b1, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        cap_in = 1'b0;
        cyc(5);
        cap_in = 1'b1;
        cyc(5);
        check_outputs("en_noarm", 16'h0019, 1'b1, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        arm_pulse();
        cyc(1);
        check_outputs("arm_dis", 16'h0019, 1'b1, 1'b0, 1'b0, 1'b0);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        check_eq("dis_ack", 32'(cap_int), 0);

        check_eq("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
